// File: rtl/dmx512_rx.sv
// DMX512-A receiver: BREAK/MAB detection, start-code and slot decoding, one write strobe per slot.
// Optional signal-loss timeout on signal_valid is built when DMX_RX_TIMEOUT_EN is defined.
module dmx512_rx #(
    parameter int CLOCKS_PER_BIT   = 96,
    parameter int BREAK_MIN_CLOCKS = 2112,
    parameter int MAB_MIN_CLOCKS   = 192,
    parameter int SLOT_COUNT       = 512,
    parameter int TIMEOUT_CLOCKS   = 24000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dmx_in,
    output logic [7:0] slot_data,
    output logic [8:0] slot_address,
    output logic       write_strobe,
    output logic [7:0] start_code,
    output logic       frame_start_strobe,
    output logic       frame_done_strobe,
    output logic [9:0] slot_count,
    output logic       framing_error,
    output logic       signal_valid
);

    typedef enum logic [2:0] {WAIT_BREAK, BREAK, MAB, START, DATA, IDLE_BYTE} state_t;

    localparam logic [11:0] BREAK_MIN = 12'(BREAK_MIN_CLOCKS);
    localparam logic [11:0] MAB_MIN   = 12'(MAB_MIN_CLOCKS);
    localparam logic [6:0]  HALF_LIM  = 7'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [6:0]  BIT_LIM   = 7'(CLOCKS_PER_BIT - 1);
    localparam logic [9:0]  SLOT_MAX  = 10'(SLOT_COUNT);

    function automatic logic [11:0] sat_inc12(input logic [11:0] v, input logic [11:0] lim);
        return (v >= lim) ? lim : v + 12'd1;
    endfunction

    state_t      state;
    logic        sync1, line, line_d;
    logic [11:0] low_cnt, mab_cnt;
    logic [6:0]  bit_timer;
    logic [3:0]  bit_idx;
    logic [7:0]  shreg;
    logic [9:0]  slot_cnt;
    logic        done_sent;
    logic        fall, rise;

    assign fall = line_d & ~line;
    assign rise = ~line_d & line;

    // Synchronizer and edge-detect history; the line idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b1;
            line   <= 1'b1;
            line_d <= 1'b1;
        end else begin
            sync1  <= dmx_in;
            line   <= sync1;
            line_d <= line;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= WAIT_BREAK;
            low_cnt            <= '0;
            mab_cnt            <= '0;
            bit_timer          <= '0;
            bit_idx            <= '0;
            shreg              <= '0;
            slot_cnt           <= '0;
            done_sent          <= 1'b0;
            slot_data          <= '0;
            slot_address       <= '0;
            write_strobe       <= 1'b0;
            start_code         <= '0;
            frame_start_strobe <= 1'b0;
            frame_done_strobe  <= 1'b0;
            slot_count         <= '0;
            framing_error      <= 1'b0;
        end else begin
            write_strobe       <= 1'b0;
            frame_start_strobe <= 1'b0;
            frame_done_strobe  <= 1'b0;
            low_cnt            <= line ? 12'd0 : sat_inc12(low_cnt, BREAK_MIN);

            if (low_cnt == BREAK_MIN && state != BREAK) begin
                // A long low aborts whatever was happening; close an open frame once.
                state <= BREAK;
                if (!done_sent && (state == START || state == DATA || slot_cnt != 10'd0)) begin
                    frame_done_strobe <= 1'b1;
                    slot_count        <= slot_cnt;
                end
                slot_cnt  <= '0;
                done_sent <= 1'b0;
            end else begin
                case (state)
                    WAIT_BREAK: ;
                    BREAK: if (rise) begin
                        state   <= MAB;
                        mab_cnt <= '0;
                    end
                    MAB: begin
                        if (fall) begin
                            state     <= (mab_cnt >= MAB_MIN) ? START : WAIT_BREAK;
                            bit_timer <= '0;
                            bit_idx   <= '0;
                        end else begin
                            mab_cnt <= sat_inc12(mab_cnt, MAB_MIN);
                        end
                    end
                    IDLE_BYTE: if (fall) begin
                        state     <= DATA;
                        bit_timer <= '0;
                        bit_idx   <= '0;
                    end
                    START, DATA: begin
                        // bit_idx 0 = start bit, 1..8 = data LSB first, 9 = stop bit.
                        if (bit_timer == ((bit_idx == 4'd0) ? HALF_LIM : BIT_LIM)) begin
                            bit_timer <= '0;
                            bit_idx   <= bit_idx + 4'd1;
                            if (bit_idx == 4'd0) begin
                                if (line) state <= (state == START) ? WAIT_BREAK : IDLE_BYTE;
                            end else if (bit_idx <= 4'd8) begin
                                shreg <= {line, shreg[7:1]};
                            end else if (!line) begin
                                framing_error <= 1'b1;
                                state         <= WAIT_BREAK;
                            end else if (state == START) begin
                                start_code         <= shreg;
                                frame_start_strobe <= 1'b1;
                                slot_cnt           <= '0;
                                framing_error      <= 1'b0;
                                done_sent          <= 1'b0;
                                state              <= IDLE_BYTE;
                            end else begin
                                if (slot_cnt < SLOT_MAX) begin
                                    slot_data    <= shreg;
                                    slot_address <= slot_cnt[8:0];
                                    write_strobe <= 1'b1;
                                    slot_cnt     <= slot_cnt + 10'd1;
                                    if (slot_cnt == SLOT_MAX - 10'd1) begin
                                        frame_done_strobe <= 1'b1;
                                        slot_count        <= SLOT_MAX;
                                        done_sent         <= 1'b1;
                                    end
                                end
                                state <= IDLE_BYTE;
                            end
                        end else begin
                            bit_timer <= bit_timer + 7'd1;
                        end
                    end
                    default: state <= WAIT_BREAK;
                endcase
            end
        end
    end

`ifdef DMX_RX_TIMEOUT_EN
    localparam logic [24:0] TMO = 25'(TIMEOUT_CLOCKS);
    logic [24:0] tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt      <= '0;
            signal_valid <= 1'b0;
        end else if (frame_start_strobe) begin
            tmo_cnt      <= '0;
            signal_valid <= 1'b1;
        end else if (tmo_cnt != TMO) begin
            tmo_cnt <= tmo_cnt + 25'd1;
            if (tmo_cnt == TMO - 25'd1) signal_valid <= 1'b0;
        end
    end
`else
    assign signal_valid = 1'b1;
`endif

endmodule

// File: tb/tb_dmx512_rx.sv
// Scoreboard bench for dmx512_rx with shortened bit timing (8 clocks per bit).
module tb_dmx512_rx;
    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dmx_in = 1'b1;
    logic [7:0] slot_data;
    logic [8:0] slot_address;
    logic       write_strobe;
    logic [7:0] start_code;
    logic       frame_start_strobe;
    logic       frame_done_strobe;
    logic [9:0] slot_count;
    logic       framing_error;
    logic       signal_valid;

    dmx512_rx #(
        .CLOCKS_PER_BIT(CPB), .BREAK_MIN_CLOCKS(176), .MAB_MIN_CLOCKS(16),
        .SLOT_COUNT(512), .TIMEOUT_CLOCKS(1000)
    ) dut (
        .clk(clk), .rst(rst), .dmx_in(dmx_in),
        .slot_data(slot_data), .slot_address(slot_address), .write_strobe(write_strobe),
        .start_code(start_code), .frame_start_strobe(frame_start_strobe),
        .frame_done_strobe(frame_done_strobe), .slot_count(slot_count),
        .framing_error(framing_error), .signal_valid(signal_valid)
    );

    always #5 clk = ~clk;

    typedef struct { logic [8:0] addr; logic [7:0] data; } wr_t;
    typedef struct { logic [9:0] cnt; logic with_wr; } fd_t;
    wr_t        wr_q[$];
    logic [7:0] fs_q[$];
    fd_t        fd_q[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s: strobe seen, none expected", name);
    endtask

    // Monitor: pops an expectation whenever the DUT presents a strobe.
    wr_t w;
    fd_t f;
    logic [7:0] c;
    logic prev_valid = 1'b0;
    int   high_cycles = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid  = signal_valid;
            high_cycles = 0;
        end else begin
            if (write_strobe) begin
                if (wr_q.size() == 0) unexpected("write_strobe");
                else begin
                    w = wr_q.pop_front();
                    check("slot_address", 32'(slot_address), 32'(w.addr));
                    check("slot_data", 32'(slot_data), 32'(w.data));
                end
            end
            if (frame_start_strobe) begin
                if (fs_q.size() == 0) unexpected("frame_start_strobe");
                else begin
                    c = fs_q.pop_front();
                    check("start_code", 32'(start_code), 32'(c));
                    check("start_vs_write", 32'(write_strobe), 32'd0);
                end
            end
            if (frame_done_strobe) begin
                if (fd_q.size() == 0) unexpected("frame_done_strobe");
                else begin
                    f = fd_q.pop_front();
                    check("slot_count", 32'(slot_count), 32'(f.cnt));
                    check("done_with_write", 32'(write_strobe), 32'(f.with_wr));
                end
            end
`ifdef DMX_RX_TIMEOUT_EN
            if (frame_start_strobe) high_cycles = 0;
            else if (signal_valid) high_cycles++;
            if (prev_valid && !signal_valid) check("valid_duration", 32'(high_cycles), 32'd1000);
`endif
            prev_valid = signal_valid;
        end
    end

    task automatic drive(input logic lvl, input int n);
        dmx_in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        drive(1'b1, 2 * CPB);
    endtask

    task automatic do_break();
        drive(1'b0, 200);
        drive(1'b1, 24);
    endtask

    task automatic exp_wr(input int a, input int d);
        wr_t e;
        e.addr = 9'(a);
        e.data = 8'(d);
        wr_q.push_back(e);
    endtask

    task automatic exp_fd(input int n, input logic ww);
        fd_t e;
        e.cnt = 10'(n);
        e.with_wr = ww;
        fd_q.push_back(e);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check("rst_slot_data", 32'(slot_data), 32'd0);
        check("rst_slot_address", 32'(slot_address), 32'd0);
        check("rst_start_code", 32'(start_code), 32'd0);
        check("rst_slot_count", 32'(slot_count), 32'd0);
        check("rst_framing_error", 32'(framing_error), 32'd0);
        check("rst_strobes", 32'({write_strobe, frame_start_strobe, frame_done_strobe}), 32'd0);
`ifdef DMX_RX_TIMEOUT_EN
        check("rst_signal_valid", 32'(signal_valid), 32'd0);
`else
        check("rst_signal_valid", 32'(signal_valid), 32'd1);
`endif
        rst = 1'b0;
        drive(1'b1, 20);

        // Short low pulse then a byte: not a BREAK, nothing decoded.
        drive(1'b0, 100);
        drive(1'b1, 20);
        send_byte(8'h55);
        drive(1'b1, 20);

        // Small frame: start code 0x00, three slots, closed by the next BREAK.
        fs_q.push_back(8'h00);
        exp_wr(0, 8'h11); exp_wr(1, 8'h22); exp_wr(2, 8'h33);
        exp_fd(3, 1'b0);
        do_break();
        send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        do_break();

        // Full frame: 512 slots, done coincides with slot 511, extras dropped.
        fs_q.push_back(8'h00);
        for (int i = 0; i < 512; i++) exp_wr(i, i & 255);
        exp_fd(512, 1'b1);
        send_byte(8'h00);
        for (int i = 0; i < 512; i++) send_byte(8'(i));
        for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i));
        do_break();

        // Framing error on slot 2 (whole byte low), then ignored until BREAK.
        fs_q.push_back(8'h00);
        exp_wr(0, 8'hA0); exp_wr(1, 8'hA1);
        exp_fd(2, 1'b0);
        send_byte(8'h00);
        send_byte(8'hA0); send_byte(8'hA1);
        drive(1'b0, 11 * CPB);
        drive(1'b1, 2 * CPB);
        send_byte(8'h77);
        check("framing_error_set", 32'(framing_error), 32'd1);
        do_break();

        // Next frame clears the error; reset strikes during bit 4 of slot 5.
        fs_q.push_back(8'h00);
        for (int i = 0; i < 5; i++) exp_wr(i, 8'h50 + i);
        send_byte(8'h00);
        check("framing_error_clear", 32'(framing_error), 32'd0);
        for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i));
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(1'b1 ^ 1'(i & 1), CPB);
        dmx_in = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_slot_data", 32'(slot_data), 32'd0);
        check("midrst_slot_address", 32'(slot_address), 32'd0);
        check("midrst_start_code", 32'(start_code), 32'd0);
        check("midrst_slot_count", 32'(slot_count), 32'd0);
        rst = 1'b0;
        drive(1'b0, CPB / 2);
        drive(1'b1, 40);

        // Recovery frame decodes from address 0.
        fs_q.push_back(8'hCC);
        exp_wr(0, 8'h99);
        exp_fd(1, 1'b0);
        do_break();
        send_byte(8'hCC);
        send_byte(8'h99);
        do_break();
        drive(1'b1, 1200);

        for (int i = 0; i < 2000 && (wr_q.size() + fs_q.size() + fd_q.size()) != 0; i++)
            @(posedge clk);
        check("pending_writes", 32'(wr_q.size()), 32'd0);
        check("pending_starts", 32'(fs_q.size()), 32'd0);
        check("pending_dones", 32'(fd_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
